// File: rtl/axis_uart_pkg.sv
// Shared types and helpers for the AXI-Stream UART transmit path.
package axis_uart_pkg;

    // Widest character the transmitter supports.
    localparam int unsigned MaxDataWidth = 9;

    typedef enum logic [1:0] {
        ParityNone = 2'b00,
        ParityEven = 2'b01,
        ParityOdd  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Map the raw parity_mode encoding. The spare code 2'b11 also means no parity.
    function automatic parity_e parity_decode(input logic [1:0] mode);
        case (mode)
            2'b01:   return ParityEven;
            2'b10:   return ParityOdd;
            default: return ParityNone;
        endcase
    endfunction

    // Parity bit for a zero-extended character. Zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [MaxDataWidth-1:0] data, input parity_e mode);
        return (mode == ParityOdd) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two, at least 2.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned LevelWidth = PtrWidth + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [LevelWidth-1:0] level_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (level_q == LevelWidth'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Ignore requests that would overflow or underflow.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally; level tracks push/pop, unchanged when both happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LevelWidth'(1);
                2'b01:   level_q <= level_q - LevelWidth'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/axis_uart_tx_fifo.sv
// AXI4-Stream to UART transmitter with buffered, gap-free back-to-back frames.
module axis_uart_tx_fifo
    import axis_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits
);

    localparam int unsigned LevelWidth  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BitCntWidth = $clog2(DATA_WIDTH + 1);

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DATA_WIDTH-1:0]     fifo_rdata;
    logic                      push;
    logic                      pop;
    logic                      last_stop;
    logic [PRESCALE_WIDTH-1:0] pre_load;
    parity_e                   frame_parity;
    logic                      tready_d;
    logic                      tready_q;

    tx_state_e                 state_q;
    logic                      txd_q;
    logic                      busy_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic [PRESCALE_WIDTH-1:0] timer_q;
    logic [BitCntWidth-1:0]    bit_cnt_q;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      stop_more_q;

    axis_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (s_axis_tdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Handshake, pop decision and next-cycle fullness for the registered ready.
    always_comb begin
        push         = s_axis_tvalid && tready_q;
        last_stop    = (state_q == StStop) && (timer_q == '0) && !stop_more_q;
        pop          = !fifo_empty && ((state_q == StIdle) || last_stop);
        pre_load     = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
        frame_parity = parity_decode(parity_mode);
        tready_d     = !((fifo_full && !pop) ||
                         ((fifo_level == LevelWidth'(FIFO_DEPTH - 1)) && push && !pop));
    end

    // Ready reflects the FIFO state of the coming cycle; held low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= tready_d;
        end
    end

    // Frame FSM: a pop (from idle or in the final stop cycle) starts a new frame directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            shift_q     <= '0;
            pre_q       <= '0;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_more_q <= 1'b0;
        end else if (pop) begin
            state_q     <= StStart;
            txd_q       <= 1'b0;
            busy_q      <= 1'b1;
            shift_q     <= fifo_rdata;
            pre_q       <= pre_load;
            timer_q     <= pre_load;
            bit_cnt_q   <= '0;
            par_en_q    <= (frame_parity != ParityNone);
            par_bit_q   <= parity_bit(MaxDataWidth'(fifo_rdata), frame_parity);
            stop_more_q <= stop_bits;
        end else if (state_q != StIdle) begin
            if (timer_q != '0) begin
                timer_q <= timer_q - PRESCALE_WIDTH'(1);
            end else begin
                timer_q <= pre_q;
                unique case (state_q)
                    StStart: begin
                        state_q   <= StData;
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= BitCntWidth'(1);
                    end
                    StData: begin
                        if (bit_cnt_q == BitCntWidth'(DATA_WIDTH)) begin
                            state_q <= par_en_q ? StParity : StStop;
                            txd_q   <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BitCntWidth'(1);
                        end
                    end
                    StParity: begin
                        state_q <= StStop;
                        txd_q   <= 1'b1;
                    end
                    StStop: begin
                        if (stop_more_q) begin
                            stop_more_q <= 1'b0;
                        end else begin
                            // Final stop cycle with an empty FIFO.
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign tx_busy       = busy_q;

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// Randomised bench for axis_uart_tx_fifo against a queue-based line-waveform model.
module tb_axis_uart_tx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          txd;
    logic          tx_busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [PW-1:0] prescale = 16'd4;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop_bits = 1'b0;

    axis_uart_tx_fifo #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .fifo_level    (fifo_level),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: expected txd per upcoming cycle, queued words, expected ready.
    bit          wave[$];
    logic [DW-1:0] mq[$];
    bit          m_ready = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          start_cyc = 0;
    int          busy_run = 0;
    int          last_run = 0;
    int          max_level = 0;
    bit          prev_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Append one whole frame, bit by bit, each repeated for the bit period.
    function automatic int build_frame(input logic [DW-1:0] w, input logic [PW-1:0] p,
                                       input logic [1:0] pm, input logic sb);
        bit bits[$];
        int reps = (p == 0) ? 1 : int'(p);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (pm == 2'b01) bits.push_back(^w);
        else if (pm == 2'b10) bits.push_back(~(^w));
        bits.push_back(1'b1);
        if (sb) bits.push_back(1'b1);
        foreach (bits[i]) for (int r = 0; r < reps; r++) wave.push_back(bits[i]);
        return bits.size() * reps;
    endfunction

    // Compare every cycle, then advance the model by one cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_txd", int'(txd), 1);
            check("rst_tx_busy", int'(tx_busy), 0);
            check("rst_tready", int'(s_axis_tready), 0);
            check("rst_fifo_level", int'(fifo_level), 0);
            wave.delete();
            mq.delete();
            m_ready   = 1'b0;
            busy_run  = 0;
            prev_busy = 1'b0;
        end else begin
            check("txd", int'(txd), (wave.size() > 0) ? int'(wave[0]) : 1);
            check("tx_busy", int'(tx_busy), (wave.size() > 0) ? 1 : 0);
            check("tready", int'(s_axis_tready), int'(m_ready));
            check("fifo_level", int'(fifo_level), mq.size());
            if (tx_busy && !prev_busy) start_cyc = cyc;
            if (tx_busy) busy_run++;
            else if (prev_busy) begin
                last_run = busy_run;
                busy_run = 0;
            end
            prev_busy = tx_busy;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && mq.size() > 0)
                void'(build_frame(mq.pop_front(), prescale, parity_mode, stop_bits));
            if (s_axis_tvalid && m_ready) begin
                mq.push_back(s_axis_tdata);
                acc_cyc = cyc;
            end
            m_ready = (mq.size() != DEPTH);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        for (int i = 0; i < 1000; i++) begin
            if (s_axis_tready) begin
                step();
                return;
            end
            step();
        end
        bound_expired("push_word");
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!tx_busy && fifo_level == 0) begin
                step();
                return;
            end
            step();
        end
        bound_expired("wait_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic [9:0] pat;

        // Pin the model against hand-derived frames.
        n = build_frame(8'h55, 16'd4, 2'b00, 1'b0);
        check("pin_len_8n1", n, 40);
        for (int i = 0; i < 10; i++) pat[i] = wave[4*i];
        check("pin_bits_8n1", int'(pat), int'(10'b1010101010));
        wave.delete();
        n = build_frame(8'h55, 16'd4, 2'b01, 1'b0);
        check("pin_len_even", n, 44);
        check("pin_par_even", int'(wave[36]), 0);
        wave.delete();
        n = build_frame(8'h55, 16'd4, 2'b10, 1'b0);
        check("pin_par_odd", int'(wave[36]), 1);
        wave.delete();
        n = build_frame(8'h55, 16'd4, 2'b00, 1'b1);
        check("pin_len_2stop", n, 44);
        wave.delete();
        n = build_frame(8'hA3, 16'd0, 2'b11, 1'b0);
        check("pin_len_pre0", n, 10);
        wave.delete();

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // Single 0x55, 8N1, prescale 4.
        push_word(8'h55);
        s_axis_tvalid = 1'b0;
        wait_idle(500);
        step();
        check("t1_start_latency", start_cyc - acc_cyc, 2);
        check("t1_busy_cycles", last_run, 40);

        // Even then odd parity.
        parity_mode = 2'b01;
        push_word(8'h55);
        s_axis_tvalid = 1'b0;
        wait_idle(500);
        step();
        check("t2_even_cycles", last_run, 44);
        parity_mode = 2'b10;
        push_word(8'h55);
        s_axis_tvalid = 1'b0;
        wait_idle(500);
        step();
        check("t2_odd_cycles", last_run, 44);

        // Three back-to-back frames with two stop bits.
        parity_mode = 2'b00;
        stop_bits   = 1'b1;
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        s_axis_tvalid = 1'b0;
        wait_idle(1000);
        step();
        check("t3_busy_cycles", last_run, 132);

        // Six words into a four-deep FIFO.
        stop_bits = 1'b0;
        max_level = 0;
        for (int i = 0; i < 6; i++) push_word(DW'($urandom));
        s_axis_tvalid = 1'b0;
        wait_idle(2000);
        step();
        check("t4_max_level", max_level, 4);

        // Prescale change during frame 1 applies to frame 2 only.
        push_word(8'h3C);
        push_word(8'hC3);
        s_axis_tvalid = 1'b0;
        repeat (10) step();
        prescale = 16'd8;
        wait_idle(1000);
        step();
        check("t5_busy_cycles", last_run, 120);

        // Reset in the middle of DATA with three words still queued.
        prescale = 16'd4;
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        s_axis_tvalid = 1'b0;
        repeat (12) step();
        check("t6_level_before", int'(fifo_level), 3);
        rst = 1'b1;
        #1;
        check("t6_txd_async", int'(txd), 1);
        check("t6_level_async", int'(fifo_level), 0);
        step();
        step();
        rst = 1'b0;
        repeat (200) step();
        check("t6_busy_after", int'(tx_busy), 0);

        // Random traffic and configuration.
        for (int i = 0; i < 400; i++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = DW'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                prescale    = PW'($urandom_range(0, 3));
                parity_mode = 2'($urandom_range(0, 3));
                stop_bits   = 1'($urandom_range(0, 1));
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        wait_idle(3000);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
